// File: rtl/cache_line_refill_ctrl_if.sv
// Main-memory word port between the refill controller (master) and the memory (slave).
// One request per cycle while mem_req is high; a read returns exactly one mem_rvalid beat.
interface cache_line_refill_ctrl_if #(
  parameter int unsigned dataWidth = 32
) ();
  logic                 mem_req;
  logic                 mem_we;
  logic [31:0]          mem_addr;
  logic [dataWidth-1:0] mem_wdata;
  logic                 mem_ready;
  logic                 mem_rvalid;
  logic [dataWidth-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/cache_line_refill_ctrl.sv
// Line refill controller for a 4-way cache bank: optional write-back of the dirty victim,
// then a word-by-word fetch of the new line with per-way bank write strobes.
module cache_line_refill_ctrl #(
  parameter int unsigned tagSize    = 24,
  parameter int unsigned indexWidth = 4,
  parameter int unsigned dataWidth  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  miss_req,
  input  logic [1:0]            miss_way,
  input  logic                  miss_dirty,
  input  logic [tagSize-1:0]    miss_tag,
  input  logic [tagSize-1:0]    victim_tag,
  input  logic [indexWidth-1:0] miss_index,
  input  logic [dataWidth-1:0]  bank_rdata,
  output logic [1:0]            bank_way_sel,
  output logic [1:0]            bank_offset,
  output logic [dataWidth-1:0]  refill_data,
  output logic                  wEnMainMemW0,
  output logic                  wEnMainMemW1,
  output logic                  wEnMainMemW2,
  output logic                  wEnMainMemW3,
  output logic                  busy,
  output logic                  refill_done,
  cache_line_refill_ctrl_if.master mem
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWb     = 3'd1;
  localparam logic [2:0] StRdReq  = 3'd2;
  localparam logic [2:0] StRdWait = 3'd3;
  localparam logic [2:0] StFill   = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [1:0]            way_q, way_d;
  logic [tagSize-1:0]    tag_q, tag_d;
  logic [tagSize-1:0]    vtag_q, vtag_d;
  logic [indexWidth-1:0] index_q, index_d;
  logic [dataWidth-1:0]  refill_data_q, refill_data_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    way_d         = way_q;
    tag_d         = tag_q;
    vtag_d        = vtag_q;
    index_d       = index_q;
    refill_data_d = refill_data_q;
    unique case (state_q)
      StIdle: begin
        if (miss_req) begin
          way_d   = miss_way;
          tag_d   = miss_tag;
          vtag_d  = victim_tag;
          index_d = miss_index;
          cnt_d   = 2'd0;
          state_d = miss_dirty ? StWb : StRdReq;
        end
      end
      StWb: begin
        if (mem.mem_ready) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = StRdReq;
        end
      end
      StRdReq: begin
        if (mem.mem_ready) state_d = StRdWait;
      end
      StRdWait: begin
        if (mem.mem_rvalid) begin
          refill_data_d = mem.mem_rdata;
          state_d       = StFill;
        end
      end
      StFill: begin
        cnt_d   = cnt_q + 2'd1;
        state_d = (cnt_q == 2'd3) ? StDone : StRdReq;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      cnt_q         <= 2'd0;
      way_q         <= 2'd0;
      tag_q         <= '0;
      vtag_q        <= '0;
      index_q       <= '0;
      refill_data_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      way_q         <= way_d;
      tag_q         <= tag_d;
      vtag_q        <= vtag_d;
      index_q       <= index_d;
      refill_data_q <= refill_data_d;
    end
  end

  // Moore outputs; only mem_wdata passes an input straight through.
  always_comb begin
    mem.mem_req   = (state_q == StWb) || (state_q == StRdReq);
    mem.mem_we    = (state_q == StWb);
    mem.mem_addr  = (state_q == StWb) ? {vtag_q, index_q, cnt_q, 2'b00}
                                      : {tag_q, index_q, cnt_q, 2'b00};
    mem.mem_wdata = bank_rdata;
    bank_way_sel  = way_q;
    bank_offset   = cnt_q;
    refill_data   = refill_data_q;
    busy          = (state_q != StIdle);
    refill_done   = (state_q == StDone);
    wEnMainMemW0  = (state_q == StFill) && (way_q == 2'd0);
    wEnMainMemW1  = (state_q == StFill) && (way_q == 2'd1);
    wEnMainMemW2  = (state_q == StFill) && (way_q == 2'd2);
    wEnMainMemW3  = (state_q == StFill) && (way_q == 2'd3);
  end

endmodule

// File: tb/tb_cache_line_refill_ctrl.sv
// Bench for cache_line_refill_ctrl: table of miss transactions plus hand-written corner cases,
// with a memory/bank model and a scoreboard of expected memory requests and fill strobes.
module tb_cache_line_refill_ctrl;

  typedef struct {
    logic [1:0]  way;
    logic        dirty;
    logic [23:0] tag;
    logic [23:0] vtag;
    logic [3:0]  idx;
    int          rdy_dly;
    int          rv_dly;
    logic [31:0] mul;
    bit          spur;
    bit          lat;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mexp_t;

  typedef struct {
    logic [1:0]  way;
    logic [1:0]  off;
    logic [31:0] data;
  } fexp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        miss_req, miss_dirty;
  logic [1:0]  miss_way;
  logic [23:0] miss_tag, victim_tag;
  logic [3:0]  miss_index;
  logic [31:0] bank_rdata, refill_data;
  logic [1:0]  bank_way_sel, bank_offset;
  logic        w0, w1, w2, w3, busy, refill_done;

  cache_line_refill_ctrl_if #(.dataWidth(32)) mem_if ();

  cache_line_refill_ctrl #(.tagSize(24), .indexWidth(4), .dataWidth(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .miss_req     (miss_req),
    .miss_way     (miss_way),
    .miss_dirty   (miss_dirty),
    .miss_tag     (miss_tag),
    .victim_tag   (victim_tag),
    .miss_index   (miss_index),
    .bank_rdata   (bank_rdata),
    .bank_way_sel (bank_way_sel),
    .bank_offset  (bank_offset),
    .refill_data  (refill_data),
    .wEnMainMemW0 (w0),
    .wEnMainMemW1 (w1),
    .wEnMainMemW2 (w2),
    .wEnMainMemW3 (w3),
    .busy         (busy),
    .refill_done  (refill_done),
    .mem          (mem_if.master)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mexp_t mem_q[$];
  fexp_t fill_q[$];

  // Scoreboard/model state
  int          cur_rdy_dly = 0, cur_rv_dly = 0;
  logic [31:0] cur_mul = 32'h1;
  bit          spur_en = 1'b0, txn_active = 1'b0;
  bit          rd_out = 1'b0, have_prev = 1'b0;
  int          stall = 0, rv_cnt = 0;
  logic [31:0] rd_word, prev_addr, prev_wdata;
  logic        prev_we;
  int          done_cnt = 0, done_cyc = 0, strobe_total = 0;
  int          drive_cyc = 0, done_base = 0;
  mexp_t       m_e;
  fexp_t       f_e;
  logic [3:0]  wen;
  logic [1:0]  wway;
  vec_t        vecs[4];

  function automatic logic [31:0] bank_val(input logic [1:0] w, input logic [1:0] o);
    return 32'hA0 + {30'd0, o} + (({30'd0, w}) ^ 32'd1) * 32'h100;
  endfunction

  assign bank_rdata = bank_val(bank_way_sel, bank_offset);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory slave model and output monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      mem_if.mem_ready  = 1'b0;
      mem_if.mem_rvalid = 1'b0;
      mem_if.mem_rdata  = '0;
      rd_out = 1'b0; stall = 0; have_prev = 1'b0;
    end else begin
      mem_if.mem_rvalid = 1'b0;
      if (rd_out) begin
        if (rv_cnt == cur_rv_dly) begin
          mem_if.mem_rvalid = 1'b1;
          mem_if.mem_rdata  = rd_word;
          rd_out = 1'b0;
        end else rv_cnt++;
      end else if (spur_en) begin
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = 32'hDEAD_BEEF;
      end
      mem_if.mem_ready = 1'b0;
      if (mem_if.mem_req) begin
        if (have_prev) begin
          chk("stall addr stable", mem_if.mem_addr, prev_addr);
          chk("stall wdata stable", mem_if.mem_wdata, prev_wdata);
          chk("stall we stable", {31'd0, mem_if.mem_we}, {31'd0, prev_we});
        end
        if (stall == cur_rdy_dly) begin
          mem_if.mem_ready = 1'b1;
          stall = 0; have_prev = 1'b0;
          chk("mem request expected", {31'd0, mem_q.size() != 0}, 32'd1);
          if (mem_q.size() != 0) begin
            m_e = mem_q.pop_front();
            chk("mem_we", {31'd0, mem_if.mem_we}, {31'd0, m_e.we});
            chk("mem_addr", mem_if.mem_addr, m_e.addr);
            if (m_e.we) chk("mem_wdata", mem_if.mem_wdata, m_e.wdata);
          end
          if (!mem_if.mem_we) begin
            rd_out  = 1'b1;
            rv_cnt  = 0;
            rd_word = cur_mul * ({30'd0, mem_if.mem_addr[3:2]} + 32'd1);
          end
        end else begin
          stall++;
          have_prev  = 1'b1;
          prev_addr  = mem_if.mem_addr;
          prev_wdata = mem_if.mem_wdata;
          prev_we    = mem_if.mem_we;
        end
      end else have_prev = 1'b0;

      wen = {w3, w2, w1, w0};
      if (wen != 4'd0) begin
        strobe_total++;
        chk("strobe one-hot", {31'd0, $countones(wen) == 1}, 32'd1);
        chk("strobe expected", {31'd0, fill_q.size() != 0}, 32'd1);
        wway = wen[1] ? 2'd1 : wen[2] ? 2'd2 : wen[3] ? 2'd3 : 2'd0;
        if (fill_q.size() != 0) begin
          f_e = fill_q.pop_front();
          chk("strobe way", {30'd0, wway}, {30'd0, f_e.way});
          chk("fill bank_way_sel", {30'd0, bank_way_sel}, {30'd0, f_e.way});
          chk("fill offset", {30'd0, bank_offset}, {30'd0, f_e.off});
          chk("fill data", refill_data, f_e.data);
        end
      end
      if (txn_active) chk("busy", {31'd0, busy}, 32'd1);
      if (refill_done) begin
        chk("refill_done in txn", {31'd0, txn_active}, 32'd1);
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic push_exp(input vec_t v);
    for (int o = 0; o < 4; o++) begin
      if (v.dirty)
        mem_q.push_back('{we: 1'b1, addr: {v.vtag, v.idx, o[1:0], 2'b00},
                          wdata: bank_val(v.way, o[1:0])});
    end
    for (int o = 0; o < 4; o++) begin
      mem_q.push_back('{we: 1'b0, addr: {v.tag, v.idx, o[1:0], 2'b00}, wdata: 32'h0});
      fill_q.push_back('{way: v.way, off: o[1:0], data: v.mul * (o + 1)});
    end
  endtask

  task automatic start_vec(input vec_t v);
    push_exp(v);
    @(posedge clk); #2;
    cur_rdy_dly = v.rdy_dly; cur_rv_dly = v.rv_dly; cur_mul = v.mul; spur_en = v.spur;
    miss_way = v.way; miss_dirty = v.dirty; miss_tag = v.tag;
    victim_tag = v.vtag; miss_index = v.idx; miss_req = 1'b1;
    drive_cyc = cyc; done_base = done_cnt;
    @(posedge clk); #2;
    miss_req = 1'b0;
    miss_way = ~v.way; miss_tag = ~v.tag; victim_tag = ~v.vtag; miss_index = ~v.idx;
    miss_dirty = ~v.dirty;
    txn_active = 1'b1;
  endtask

  task automatic finish_vec(input vec_t v, input string nm);
    int n = 0;
    while (done_cnt == done_base && n < 400) begin
      @(posedge clk); n++;
    end
    #2;
    txn_active = 1'b0;
    spur_en = 1'b0;
    chk({nm, " refill_done count"}, done_cnt - done_base, 32'd1);
    if (v.lat) chk({nm, " latency"}, done_cyc - drive_cyc, v.dirty ? 32'd17 : 32'd13);
    repeat (2) @(posedge clk);
    #2;
    chk({nm, " mem_q drained"}, mem_q.size(), 32'd0);
    chk({nm, " fill_q drained"}, fill_q.size(), 32'd0);
    chk({nm, " idle after"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " busy"}, {31'd0, busy}, 32'd0);
    chk({nm, " mem_req"}, {31'd0, mem_if.mem_req}, 32'd0);
    chk({nm, " mem_we"}, {31'd0, mem_if.mem_we}, 32'd0);
    chk({nm, " strobes"}, {28'd0, w3, w2, w1, w0}, 32'd0);
    chk({nm, " refill_done"}, {31'd0, refill_done}, 32'd0);
    chk({nm, " bank_way_sel/offset"}, {28'd0, bank_way_sel, bank_offset}, 32'd0);
    chk({nm, " mem_addr"}, mem_if.mem_addr, 32'd0);
    chk({nm, " refill_data"}, refill_data, 32'd0);
  endtask

  initial begin
    vec_t v;
    int   n, sbase;
    vecs[0] = '{way: 2'd2, dirty: 1'b0, tag: 24'hABCDE1, vtag: 24'h0, idx: 4'd5,
                rdy_dly: 0, rv_dly: 0, mul: 32'h11, spur: 1'b0, lat: 1'b1};
    vecs[1] = '{way: 2'd1, dirty: 1'b1, tag: 24'h123456, vtag: 24'h000010, idx: 4'd5,
                rdy_dly: 0, rv_dly: 0, mul: 32'h101, spur: 1'b0, lat: 1'b1};
    vecs[2] = '{way: 2'd0, dirty: 1'b1, tag: 24'h00BEEF, vtag: 24'hC0FFEE, idx: 4'd9,
                rdy_dly: 5, rv_dly: 7, mul: 32'h3003, spur: 1'b0, lat: 1'b0};
    vecs[3] = '{way: 2'd3, dirty: 1'b1, tag: 24'h777777, vtag: 24'h555555, idx: 4'd15,
                rdy_dly: 0, rv_dly: 0, mul: 32'h9, spur: 1'b1, lat: 1'b1};

    reset = 1'b0; miss_req = 1'b0; miss_way = 2'd0; miss_dirty = 1'b0;
    miss_tag = '0; victim_tag = '0; miss_index = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(posedge clk); #2;
    reset = 1'b1;

    for (int i = 0; i < 4; i++) begin
      v = vecs[i];
      start_vec(v);
      finish_vec(v, $sformatf("vec%0d", i));
    end

    // Spurious mem_rvalid while idle
    sbase = strobe_total;
    spur_en = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    spur_en = 1'b0;
    chk("spurious idle busy", {31'd0, busy}, 32'd0);
    chk("spurious idle strobes", strobe_total - sbase, 32'd0);

    // miss_req pulsed while busy must be ignored
    v = '{way: 2'd2, dirty: 1'b0, tag: 24'h55AA11, vtag: 24'h0, idx: 4'd3,
          rdy_dly: 0, rv_dly: 2, mul: 32'h7, spur: 1'b0, lat: 1'b0};
    start_vec(v);
    repeat (3) @(posedge clk);
    #2;
    miss_way = 2'd0; miss_dirty = 1'b1; miss_tag = 24'hFFFFFF; victim_tag = 24'h111111;
    miss_req = 1'b1;
    @(posedge clk); #2;
    miss_req = 1'b0;
    finish_vec(v, "busy-ignore");

    // Async reset while the second read is outstanding
    v = '{way: 2'd1, dirty: 1'b0, tag: 24'h0A0B0C, vtag: 24'h0, idx: 4'd7,
          rdy_dly: 0, rv_dly: 7, mul: 32'h3, spur: 1'b0, lat: 1'b0};
    sbase = strobe_total;
    start_vec(v);
    n = 0;
    while (!((strobe_total - sbase) >= 1 && rd_out) && n < 200) begin
      @(posedge clk); n++;
    end
    @(posedge clk); #2;
    chk("pre-reset strobes", strobe_total - sbase, 32'd1);
    reset = 1'b0;
    #1;
    chk_all_zero("abort");
    mem_q.delete();
    fill_q.delete();
    txn_active = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    sbase = strobe_total;
    repeat (4) @(posedge clk);
    #2;
    chk("no strobe after abort", strobe_total - sbase, 32'd0);
    v = '{way: 2'd3, dirty: 1'b0, tag: 24'h3C3C3C, vtag: 24'h0, idx: 4'd2,
          rdy_dly: 0, rv_dly: 0, mul: 32'h21, spur: 1'b0, lat: 1'b1};
    start_vec(v);
    finish_vec(v, "post-reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_line_refill_ctrl.md
Name: cache_line_refill_ctrl

Overview:
Memory-side controller for the 4-way cache bank. On a miss it writes back the dirty victim line by reading the bank word by word. It then fetches the new line from main memory one word at a time and drives the bank's per-way main-memory write enables, offset and write data. It sits between the cache miss logic and the main-memory port.

Parameters:
tagSize, 24, tag field width in bits
indexWidth, 4, set index width in bits (NoOfSets = 2**indexWidth)
dataWidth, 32, word width in bits. Only 32 is supported.
Constraint: tagSize + indexWidth + 4 == 32 (2 offset bits + 2 byte bits).

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
miss_req  input  1  start a line transaction; sampled only in IDLE
miss_way  input  2  victim way to refill
miss_dirty  input  1  victim line must be written back first
miss_tag  input  tagSize  tag of the missing line
victim_tag  input  tagSize  tag of the dirty victim line
miss_index  input  indexWidth  set index, shared by victim and new line
bank_rdata  input  dataWidth  combinational read data from the bank, selected by bank_way_sel and bank_offset
bank_way_sel  output  2  way select to the bank
bank_offset  output  2  word offset to the bank
refill_data  output  dataWidth  write data to the bank
wEnMainMemW0..wEnMainMemW3  output  1 each  per-way refill write strobes; at most one high
mem_req  output  1  memory request valid
mem_we  output  1  1 = write word, 0 = read word
mem_addr  output  32  word address: {tag, index, offset, 2'b00}
mem_wdata  output  dataWidth  write-back data, equal to bank_rdata
mem_ready  input  1  memory accepts the request this cycle
mem_rvalid  input  1  read data valid
mem_rdata  input  dataWidth  read data
busy  output  1  high in any state other than IDLE
refill_done  output  1  one-cycle pulse when the line is installed

Behaviour:
- Reset, asynchronous, active when reset is low: state = IDLE, cnt = 0, latched way/tags/index = 0, refill_data = 0. All strobes, mem_req, mem_we, busy and refill_done are 0. bank_way_sel = 0 and bank_offset = 0. Reset mid-transaction aborts it at once; no strobe is emitted afterwards.
- IDLE:
  - If miss_req = 1, latch miss_way, miss_dirty, miss_tag, victim_tag and miss_index, clear cnt, and go to WB if miss_dirty = 1, else RD_REQ.
  - miss_req is ignored in every other state.
- WB: write back one word per memory acceptance.
  - mem_req = 1, mem_we = 1, mem_addr = {victim_tag, index, cnt, 2'b00}.
  - bank_way_sel = latched way, bank_offset = cnt, mem_wdata = bank_rdata.
  - Outputs are held stable until mem_ready = 1. Then cnt increments, and when cnt = 3 cnt wraps to 0 and the state goes to RD_REQ.
- RD_REQ:
  - mem_req = 1, mem_we = 0, mem_addr = {miss_tag, index, cnt, 2'b00}.
  - On mem_ready go to RD_WAIT.
- RD_WAIT:
  - mem_req = 0. Exactly one read is outstanding.
  - On mem_rvalid capture mem_rdata into refill_data and go to FILL.
  - mem_rvalid in any other state is ignored.
- FILL:
  - The wEnMainMemW strobe of the latched way is 1 for exactly this cycle, with bank_offset = cnt, bank_way_sel = latched way, and refill_data stable.
  - Then cnt increments. If cnt was 3, go to DONE; otherwise go to RD_REQ.
- DONE: refill_done = 1 for one cycle, then IDLE.
- Outputs are Moore decodes of state and registers, with no combinational input-to-output path except mem_wdata = bank_rdata.
- Minimum latency with mem_ready and mem_rvalid each returning 1 one cycle after the request:
  - clean miss: miss_req sampled at cycle 0, refill_done at cycle 13;
  - dirty miss: 4 additional cycles.
- The offset counter wraps modulo 4, and the address offset bits always equal cnt.
- refill_data holds its last value outside FILL.

Test Plan:
- Clean miss: way = 2, index = 5, tag = 0xABCDE1, memory returns 0x11, 0x22, 0x33, 0x44 with zero wait -> four wEnMainMemW2 pulses at offsets 0..3 with those data, mem_addr 0xABCDE150/54/58/5C, refill_done at cycle 13, no other way strobed.
- Dirty miss: way = 1, victim_tag = 0x000010, bank returns 0xA0..0xA3 -> four writes at mem_addr 0x00001050..5C with mem_we = 1 and data 0xA0..0xA3, then the refill sequence, busy high throughout.
- Memory back-pressure: mem_ready held low 5 cycles in WB and in RD_REQ, and mem_rvalid delayed 7 cycles -> mem_addr, mem_wdata and mem_req stable while stalled, no extra strobes, and the correct word count.
- miss_req pulsed while busy -> ignored; the original transaction completes unchanged.
- Async reset asserted in RD_WAIT after word 1 -> all outputs 0 immediately; after release a new miss to way 3 completes normally from offset 0.
- Spurious mem_rvalid in IDLE and RD_REQ -> no strobe and no state change.
